// File: rtl/bigmul_operand_loader.sv
// Streams A/B limbs into the bigmul_unit_csa operand banks, starts the multiplier and reports lengths/cycle counts.
// Define BIGMUL_LOADER_CLEAR_EN to zero both banks before every load.
module bigmul_operand_loader #(
  parameter int unsigned NUM_LIMBS = 64,
  parameter int unsigned LIMB_W    = 64,
  parameter int unsigned IDX_W     = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [LIMB_W-1:0] in_data,
  input  logic              in_last,
  output logic              wr_a_en,
  output logic              wr_b_en,
  output logic [IDX_W-1:0]  wr_idx,
  output logic [LIMB_W-1:0] wr_data,
  output logic              mul_start,
  input  logic              mul_busy,
  input  logic              mul_done,
  input  logic [63:0]       mul_cycles,
  output logic              busy,
  output logic              done,
  output logic [IDX_W:0]    a_len,
  output logic [IDX_W:0]    b_len,
  output logic [63:0]       mul_cycles_q,
  output logic [63:0]       total_cycles,
  output logic              err_ovf
);

  localparam int unsigned LEN_W = IDX_W + 1;
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(NUM_LIMBS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD_A,
    S_LOAD_B,
    S_START,
    S_WAIT
  } state_t;

  state_t state, state_nxt;
  logic   accept;

`ifdef BIGMUL_LOADER_CLEAR_EN
  localparam logic [IDX_W-1:0] CLR_LAST = IDX_W'(NUM_LIMBS - 1);
  logic [IDX_W-1:0] clr_idx;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next state plus the combinational handshake, bank-write and start outputs
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    accept    = 1'b0;
    wr_a_en   = 1'b0;
    wr_b_en   = 1'b0;
    wr_idx    = '0;
    wr_data   = '0;
    mul_start = 1'b0;
    busy      = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (go) begin
`ifdef BIGMUL_LOADER_CLEAR_EN
          state_nxt = S_CLEAR;
`else
          state_nxt = S_LOAD_A;
`endif
        end
      end
`ifdef BIGMUL_LOADER_CLEAR_EN
      S_CLEAR: begin
        wr_a_en = 1'b1;
        wr_b_en = 1'b1;
        wr_idx  = clr_idx;
        if (clr_idx == CLR_LAST) state_nxt = S_LOAD_A;
      end
`endif
      S_LOAD_A: begin
        in_ready = 1'b1;
        accept   = in_valid;
        wr_idx   = a_len[IDX_W-1:0];
        wr_data  = in_data;
        wr_a_en  = accept && (a_len < LEN_MAX);
        if (accept && in_last) state_nxt = S_LOAD_B;
      end
      S_LOAD_B: begin
        in_ready = 1'b1;
        accept   = in_valid;
        wr_idx   = b_len[IDX_W-1:0];
        wr_data  = in_data;
        wr_b_en  = accept && (b_len < LEN_MAX);
        if (accept && in_last) state_nxt = S_START;
      end
      S_START: begin
        // A still-busy multiplier postpones the single start pulse
        if (!mul_busy) begin
          mul_start = 1'b1;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mul_done) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Lengths, overflow flag, cycle counters and done pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_len        <= '0;
      b_len        <= '0;
      err_ovf      <= 1'b0;
      total_cycles <= '0;
      mul_cycles_q <= '0;
      done         <= 1'b0;
`ifdef BIGMUL_LOADER_CLEAR_EN
      clr_idx      <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (busy) total_cycles <= total_cycles + 64'd1;
      case (state)
        S_IDLE: begin
          if (go) begin
            a_len        <= '0;
            b_len        <= '0;
            err_ovf      <= 1'b0;
            total_cycles <= '0;
`ifdef BIGMUL_LOADER_CLEAR_EN
            clr_idx      <= '0;
`endif
          end
        end
`ifdef BIGMUL_LOADER_CLEAR_EN
        S_CLEAR: clr_idx <= clr_idx + IDX_W'(1);
`endif
        // Beats past the bank depth are consumed but only flag overflow
        S_LOAD_A: begin
          if (accept) begin
            if (a_len < LEN_MAX) a_len <= a_len + LEN_W'(1);
            else                 err_ovf <= 1'b1;
          end
        end
        S_LOAD_B: begin
          if (accept) begin
            if (b_len < LEN_MAX) b_len <= b_len + LEN_W'(1);
            else                 err_ovf <= 1'b1;
          end
        end
        S_WAIT: begin
          if (mul_done) begin
            mul_cycles_q <= mul_cycles;
            done         <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/bigmul_operand_loader.md
# bigmul_operand_loader

Upstream feeder for the `bigmul_unit_csa` multi-limb multiplier. It accepts operand A and operand B as valid/ready limb streams (least-significant limb first), optionally clears both operand banks, writes the limbs into the multiplier's A/B banks and pulses the multiplier's `start`. It then waits for the multiplier's `done` and reports the operand lengths, the multiplier cycle count and the end-to-end cycle count. It replaces hierarchical-reference operand preloading, so the multiplier is driven through ports only.

## Interface
- `NUM_LIMBS`, 64: limbs per operand bank.
- `LIMB_W`, 64: bits per limb.
- `IDX_W`, 6: limb index width; must equal clog2(`NUM_LIMBS`).
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `rst`  in  1  **asynchronous, active-high reset**.
- `go`  in  1  pulse; begins a job; ignored unless state is IDLE.
- `in_valid`  in  1  input limb valid.
- `in_ready`  out  1  loader accepts a limb this cycle.
- `in_data`  in  LIMB_W  limb value.
- `in_last`  in  1  marks the final limb of the current operand.
- `wr_a_en`  out  1  write strobe, multiplier A bank.
- `wr_b_en`  out  1  write strobe, multiplier B bank.
- `wr_idx`  out  IDX_W  write limb index, shared by both banks.
- `wr_data`  out  LIMB_W  write data, shared by both banks.
- `mul_start`  out  1  one-cycle start pulse to the multiplier.
- `mul_busy`  in  1  multiplier busy.
- `mul_done`  in  1  multiplier done pulse.
- `mul_cycles`  in  64  multiplier's `cycles_out`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle job-complete pulse.
- `a_len`, `b_len`  out  IDX_W+1 each  limbs accepted per operand, saturating at `NUM_LIMBS`.
- `mul_cycles_q`  out  64  `mul_cycles` latched at `mul_done`.
- `total_cycles`  out  64  cycles from the `go` acceptance edge to the `mul_done` edge.
- `err_ovf`  out  1  sticky per job: an operand exceeded `NUM_LIMBS` limbs.

## Operation
- States: IDLE, CLEAR, LOAD_A, LOAD_B, START, WAIT.
- **IDLE**
  - When `go` is high: clear `a_len`, `b_len`, `err_ovf` and `total_cycles`, then go to CLEAR.
- **CLEAR**
  - Each cycle, `wr_a_en` = `wr_b_en` = 1, `wr_data` = 0, and `wr_idx` counts 0 .. `NUM_LIMBS`-1.
  - After the last index, go to LOAD_A.
- **LOAD_A / LOAD_B**
  - `in_ready` = 1. A beat is accepted when `in_valid` and `in_ready` are both high.
  - Writes are combinational in the accepting cycle:
    - `wr_a_en` (LOAD_A) or `wr_b_en` (LOAD_B) = accept AND index < `NUM_LIMBS`.
    - `wr_idx` = current index; `wr_data` = `in_data`.
  - Index overflow: beats past `NUM_LIMBS` are accepted and dropped, `err_ovf` is set, and the length saturates.
  - An accepted beat with `in_last` resets the index to 0 and advances LOAD_A → LOAD_B, or LOAD_B → START.
  - Minimum operand length is 1: a first beat with `in_last` high gives length 1.
- **START**
  - `mul_start` = 1 for exactly one cycle, then go to WAIT.
  - If `mul_busy` is high on entry, hold in START with `mul_start` = 0 until `mul_busy` falls.
- **WAIT**
  - On `mul_done`: latch `mul_cycles_q` from `mul_cycles`, freeze `total_cycles`, pulse `done` in the following cycle, and return to IDLE.
- `total_cycles` increments every cycle while `busy` is high.
- `go` while `busy` is high is ignored.
- `mul_done` outside WAIT is ignored.
- Outside CLEAR and the LOAD states: `in_ready` = 0, and all write strobes = 0.

## Timing
- Reset values: state IDLE; all outputs 0, including `in_ready`, strobes, `mul_start`, `done`, the lengths, both cycle counters and `err_ovf`.
- Reset asserted mid-job aborts immediately and asynchronously. No start pulse is issued, and the multiplier must be reset separately.
- Fixed latency with clear, excluding input stalls: `go` edge → first `in_ready` is `NUM_LIMBS` + 1 cycles.
- The last B beat is accepted at edge t; `mul_start` is high during cycle t+1.
- `mul_done` is sampled at edge d; `done` is high during cycle d+1.
- Back-to-back jobs: `go` is accepted in the cycle that `done` is high only if state is already IDLE, which it is.

## Configuration
- `BIGMUL_LOADER_CLEAR_EN` defined: the CLEAR state is present as described.
- Not defined: the CLEAR state is removed and IDLE goes directly to LOAD_A.
  - The `go` → `in_ready` latency becomes 1 cycle.
  - Upper limbs retain stale data; the caller guarantees they are zero.

## Test plan
- A = {0x38, 0x3}, B = {0x17}, stub multiplier asserting `done` 10 cycles after `start` and reporting `mul_cycles` = 10:
  - 64 clear writes per bank, then `wr_a_en` idx 0/1 with 0x38/0x3 and `wr_b_en` idx 0 with 0x17.
  - `mul_start` fires once.
  - `done` pulses with `a_len` = 2, `b_len` = 1, `mul_cycles_q` = 10, `err_ovf` = 0.
- Random `in_valid` gaps and an 8-limb A (limb i = i+1): writes occur only on accept cycles, indices are 0..7 in order, `a_len` = 8.
- 66-limb B: exactly 64 B writes, `b_len` = 64, `err_ovf` = 1 at `done`.
- `rst` pulsed during LOAD_B: all outputs 0 immediately, no `mul_start`, next `go` runs a clean job.
- `go` re-pulsed during WAIT, and `mul_done` pulsed during LOAD_A: both ignored, one `done` per job.
- `mul_busy` high on START entry for 5 cycles: `mul_start` is delayed until `mul_busy` falls, and is still a single pulse.
